butterfly_r2_stage: RTL and testbench



---
 rtl/dsp_pkg.sv | 28 ++
 rtl/bfly_addsub.sv | 51 +++++
 rtl/butterfly_r2_stage.sv | 136 +++++++++++++
 tb/tb_butterfly_r2_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared complex-sample helpers: field layout of a packed {re, im} word
// and the 16-bit saturation bounds used by the datapath.
package dsp_pkg;

  localparam int SMP_W  = 16;
  localparam int CPLX_W = 2 * SMP_W;
  localparam int RE_LSB = SMP_W;
  localparam int IM_LSB = 0;

  typedef logic signed [SMP_W-1:0] smp_t;
  typedef logic signed [SMP_W:0]   wide_t;

  localparam wide_t SAT_MAX = 17'sd32767;
  localparam wide_t SAT_MIN = -17'sd32768;

  function automatic smp_t cplx_re(input logic [CPLX_W-1:0] w);
    return smp_t'(w[RE_LSB +: SMP_W]);
  endfunction

  function automatic smp_t cplx_im(input logic [CPLX_W-1:0] w);
    return smp_t'(w[IM_LSB +: SMP_W]);
  endfunction

  function automatic logic [CPLX_W-1:0] cplx_pack(input smp_t re, input smp_t im);
    return {re, im};
  endfunction

endpackage

// File: rtl/bfly_addsub.sv
// One real component of a radix-2 butterfly: sum and difference in 17-bit
// arithmetic, reduced back to 16 bits by halving or by saturation.
module bfly_addsub
  import dsp_pkg::*;
#(
  parameter int SCALE = 1
) (
  input  smp_t a_i,
  input  smp_t b_i,
  output smp_t sum_o,
  output smp_t diff_o,
  output logic sum_clamp_o,
  output logic diff_clamp_o
);

  wide_t sum_w;
  wide_t diff_w;

  // Floor division by two; the 17-bit range always fits in 16 bits afterwards.
  function automatic smp_t halve(input wide_t v);
    wide_t s;
    s = v >>> 1;
    return smp_t'(s[SMP_W-1:0]);
  endfunction

  function automatic smp_t saturate(input wide_t v);
    if (v > SAT_MAX) return smp_t'(SAT_MAX[SMP_W-1:0]);
    if (v < SAT_MIN) return smp_t'(SAT_MIN[SMP_W-1:0]);
    return smp_t'(v[SMP_W-1:0]);
  endfunction

  function automatic logic out_of_range(input wide_t v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  assign sum_w  = wide_t'(a_i) + wide_t'(b_i);
  assign diff_w = wide_t'(a_i) - wide_t'(b_i);

  if (SCALE != 0) begin : g_scale
    assign sum_o        = halve(sum_w);
    assign diff_o       = halve(diff_w);
    assign sum_clamp_o  = 1'b0;
    assign diff_clamp_o = 1'b0;
  end else begin : g_sat
    assign sum_o        = saturate(sum_w);
    assign diff_o       = saturate(diff_w);
    assign sum_clamp_o  = out_of_range(sum_w);
    assign diff_clamp_o = out_of_range(diff_w);
  end

endmodule

// File: rtl/butterfly_r2_stage.sv
// First DIT radix-2 stage (twiddle 1): takes x[2n], x[2n+1] from a
// bit-reversed stream and emits a+b then a-b with a frame-position marker.
module butterfly_r2_stage
  import dsp_pkg::*;
#(
  parameter int K     = 10,
  parameter int DW    = 32,
  parameter int SCALE = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i,
  output logic          last_o,
  output logic          ovf_o
);

  if (DW != CPLX_W) begin : g_dw_check
    $error("butterfly_r2_stage: DW must be 32");
  end
  if (K < 1) begin : g_k_check
    $error("butterfly_r2_stage: K must be at least 1");
  end

  typedef enum logic [1:0] {S_A, S_B, S_SUM, S_DIFF} state_t;

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   sum_q, sum_d;
  logic [DW-1:0]   diff_q, diff_d;
  logic [K-1:0]    cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic            in_hs;
  logic            out_hs;
  smp_t            re_sum, re_diff, im_sum, im_diff;
  logic            re_sum_c, re_diff_c, im_sum_c, im_diff_c;

  assign in_hs  = valid_i && ready_q;
  assign out_hs = valid_q && ready_i;

  bfly_addsub #(.SCALE(SCALE)) u_re (
    .a_i          (cplx_re(a_q)),
    .b_i          (cplx_re(data_i)),
    .sum_o        (re_sum),
    .diff_o       (re_diff),
    .sum_clamp_o  (re_sum_c),
    .diff_clamp_o (re_diff_c)
  );

  bfly_addsub #(.SCALE(SCALE)) u_im (
    .a_i          (cplx_im(a_q)),
    .b_i          (cplx_im(data_i)),
    .sum_o        (im_sum),
    .diff_o       (im_diff),
    .sum_clamp_o  (im_sum_c),
    .diff_clamp_o (im_diff_c)
  );

  // State and handshake outputs are flopped so ready_o never sees ready_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_A;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_A:     if (in_hs)   state_d = S_B;
      S_B:     if (in_hs)   state_d = S_SUM;
      S_SUM:   if (ready_i) state_d = S_DIFF;
      S_DIFF:  if (ready_i) state_d = S_A;
      default:              state_d = S_A;
    endcase
  end

  always_comb begin
    ready_d = (state_d == S_A)   || (state_d == S_B);
    valid_d = (state_d == S_SUM) || (state_d == S_DIFF);
    ready_o = ready_q;
    valid_o = valid_q;
    data_o  = (state_q == S_DIFF) ? diff_q : sum_q;
    last_o  = valid_q && (&cnt_q);
    ovf_o   = ovf_q;
  end

  // Datapath: capture a, then both results on the b handshake.
  always_comb begin
    a_d    = a_q;
    sum_d  = sum_q;
    diff_d = diff_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    if (in_hs && state_q == S_A) begin
      a_d = data_i;
    end
    if (in_hs && state_q == S_B) begin
      sum_d  = cplx_pack(re_sum, im_sum);
      diff_d = cplx_pack(re_diff, im_diff);
      ovf_d  = ovf_q | re_sum_c | re_diff_c | im_sum_c | im_diff_c;
    end
    if (out_hs) begin
      cnt_d = cnt_q + K'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q    <= '0;
      sum_q  <= '0;
      diff_q <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      sum_q  <= sum_d;
      diff_q <= diff_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_butterfly_r2_stage.sv
// Scoreboard bench: two instances (K=2/halving, K=3/saturating) share one
// stimulus stream; a reference model queues expected words for a monitor.
module tb_butterfly_r2_stage;

  localparam int NI = 2;
  localparam int KV [NI]  = '{2, 3};
  localparam int SCV [NI] = '{1, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        ready_i = 1'b0;
  logic [1:0]  rdy, vld, lst, ovf;
  logic [31:0] dat [NI];

  always #5 clk = ~clk;

  butterfly_r2_stage #(.K(2), .DW(32), .SCALE(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .data_i(data_i),
    .ready_o(rdy[0]), .valid_o(vld[0]), .data_o(dat[0]),
    .ready_i(ready_i), .last_o(lst[0]), .ovf_o(ovf[0])
  );

  butterfly_r2_stage #(.K(3), .DW(32), .SCALE(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .data_i(data_i),
    .ready_o(rdy[1]), .valid_o(vld[1]), .data_o(dat[1]),
    .ready_i(ready_i), .last_o(lst[1]), .ovf_o(ovf[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t        expq [NI][$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] a_m;
  bit          have_a = 0;
  int          out_idx [NI];
  bit          ovf_m [NI];
  int          last_cnt [NI];
  bit          rnd_ready = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference arithmetic on plain integers: exact sum/difference, then
  // either floor(v/2) or clamp to the 16-bit signed range.
  function automatic int reduce(input int v, input bit scale, output bit clamped);
    clamped = 1'b0;
    if (scale) return (v >= 0) ? v / 2 : -((1 - v) / 2);
    if (v > 32767)  begin clamped = 1'b1; return 32767;  end
    if (v < -32768) begin clamped = 1'b1; return -32768; end
    return v;
  endfunction

  function automatic int field(input logic [31:0] w, input bit hi);
    logic signed [15:0] t;
    t = hi ? w[31:16] : w[15:0];
    return int'(t);
  endfunction

  task automatic model_accept(input logic [31:0] w);
    int          r;
    bit          c;
    logic [31:0] y0, y1;
    int          n;
    if (!have_a) begin
      a_m    = w;
      have_a = 1'b1;
      return;
    end
    have_a = 1'b0;
    for (int d = 0; d < NI; d++) begin
      r = reduce(field(a_m, 1) + field(w, 1), SCV[d] != 0, c); y0[31:16] = r[15:0]; ovf_m[d] |= c;
      r = reduce(field(a_m, 0) + field(w, 0), SCV[d] != 0, c); y0[15:0]  = r[15:0]; ovf_m[d] |= c;
      r = reduce(field(a_m, 1) - field(w, 1), SCV[d] != 0, c); y1[31:16] = r[15:0]; ovf_m[d] |= c;
      r = reduce(field(a_m, 0) - field(w, 0), SCV[d] != 0, c); y1[15:0]  = r[15:0]; ovf_m[d] |= c;
      n = 1 << KV[d];
      expq[d].push_back('{data: y0, last: (out_idx[d] % n) == n - 1, ovf: ovf_m[d]});
      out_idx[d]++;
      expq[d].push_back('{data: y1, last: (out_idx[d] % n) == n - 1, ovf: ovf_m[d]});
      out_idx[d]++;
    end
  endtask

  // Monitor: checks every output handshake and the hold-while-stalled rule.
  bit          hold [NI];
  logic [31:0] hold_data [NI];
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < NI; d++) hold[d] = 1'b0;
    end else begin
      for (int d = 0; d < NI; d++) begin
        if (hold[d]) begin
          chk($sformatf("hold_valid%0d", d), 32'(vld[d]), 32'd1);
          chk($sformatf("hold_data%0d", d), dat[d], hold_data[d]);
        end
        if (vld[d]) begin
          if (ready_i) begin
            if (expq[d].size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_out%0d: got %h, expected no output at %0t", d, dat[d], $time);
            end else begin
              mon_e = expq[d].pop_front();
              chk($sformatf("data%0d", d), dat[d], mon_e.data);
              chk($sformatf("last%0d", d), 32'(lst[d]), 32'(mon_e.last));
              chk($sformatf("ovf%0d", d), 32'(ovf[d]), 32'(mon_e.ovf));
              if (lst[d]) last_cnt[d]++;
            end
            hold[d] = 1'b0;
          end else begin
            hold[d]      = 1'b1;
            hold_data[d] = dat[d];
          end
        end else begin
          hold[d] = 1'b0;
          chk($sformatf("idle_last%0d", d), 32'(lst[d]), 32'd0);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] w);
    int t;
    valid_i = 1'b1;
    data_i  = w;
    t = 0;
    @(negedge clk);
    while (!rdy[0] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[0]) begin
      n_fail++;
      $display("FAIL send_timeout: got ready_o %b, expected 1 at %0t", rdy[0], $time);
      $fatal(1, "input handshake never completed");
    end
    @(posedge clk);
    model_accept(w);
    #1;
    valid_i = 1'b0;
    data_i  = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((expq[0].size() != 0 || expq[1].size() != 0 || vld != 2'b00) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(expq[0].size() + expq[1].size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int d = 0; d < NI; d++) begin
      expq[d].delete();
      out_idx[d] = 0;
      ovf_m[d]   = 1'b0;
    end
    have_a = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_last", 32'(lst), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(rdy), 32'd3);
    chk("rel_valid", 32'(vld), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 3))
        0: w[31:16] = 16'h7FFF;
        1: w[31:16] = 16'h8000;
        2: w[31:16] = 16'h0000;
        default: w[31:16] = 16'hFFFF;
      endcase
      case ($urandom_range(0, 3))
        0: w[15:0] = 16'h7FFF;
        1: w[15:0] = 16'h8000;
        2: w[15:0] = 16'h0001;
        default: w[15:0] = 16'hFFFF;
      endcase
    end
    return w;
  endfunction

  initial begin
    for (int d = 0; d < NI; d++) begin
      out_idx[d] = 0;
      ovf_m[d]   = 1'b0;
      last_cnt[d] = 0;
    end
    do_reset();
    ready_i = 1'b1;

    // Halving: y0 then y1 on consecutive cycles after b.
    send(32'h0004_0002);
    send(32'h0002_0002);
    @(negedge clk);
    chk("lat_y0_valid", 32'(vld[0]), 32'd1);
    chk("lat_y0_data", dat[0], 32'h0003_0002);
    chk("ovf_before_sat", 32'(ovf[1]), 32'd0);
    @(negedge clk);
    chk("lat_y1_valid", 32'(vld[0]), 32'd1);
    chk("lat_y1_data", dat[0], 32'h0001_0000);
    wait_drain();

    // Saturation corners and sticky overflow.
    send(32'h7FFF_8000);
    send(32'h0001_FFFF);
    @(negedge clk);
    chk("sat_y0", dat[1], 32'h7FFF_8000);
    chk("sat_ovf", 32'(ovf[1]), 32'd1);
    chk("scale_no_ovf", 32'(ovf[0]), 32'd0);
    @(negedge clk);
    chk("sat_y1", dat[1], 32'h7FFE_8001);
    wait_drain();
    idle(3);
    chk("ovf_sticky", 32'(ovf[1]), 32'd1);

    // Backpressure in S_SUM with an upstream word waiting.
    ready_i = 1'b0;
    send(rand_word());
    send(rand_word());
    valid_i = 1'b1;
    data_i  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(rdy), 32'd0);
      chk("bp_valid", 32'(vld[0]), 32'd1);
      chk("bp_data", dat[0], expq[0][0].data);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    wait_drain();

    // Reset with a half-received pair; the stale a must not reappear.
    send(32'h1234_5678);
    do_reset();
    send(32'h0010_0010);
    send(32'h0008_FFF8);
    wait_drain();

    // Reset while an output is stalled.
    ready_i = 1'b0;
    send(rand_word());
    send(rand_word());
    idle(2);
    do_reset();
    ready_i = 1'b1;
    idle(3);
    chk("no_stale_valid", 32'(vld), 32'd0);

    // Eight continuous samples from a fresh counter.
    last_cnt[0] = 0;
    last_cnt[1] = 0;
    for (int i = 0; i < 8; i++) send(rand_word());
    wait_drain();
    chk("last_count_k2", 32'(last_cnt[0]), 32'd2);
    chk("last_count_k3", 32'(last_cnt[1]), 32'd1);

    // Randomized gaps on both sides.
    rnd_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(rand_word());
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    ready_i = 1'b1;
    wait_drain();
    chk("pair_pending", 32'(have_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
